data_memory_rv32: RTL and testbench
===================================

Name: data_memory_rv32

Overview:
- Second-generation RISC-V data memory: word-organised RAM with byte/half/word stores via byte-lane enables, and sign/zero-extended loads decoded from funct3.
- Adds a synchronous 1-cycle read with valid strobe, base-address translation, misalignment/range fault flags, and a post-reset clear sweep.
- Sits between the datapath ALU result/rs2 and the write-back mux; the control unit stalls on Busy_o.

Parameters:
- DATA_WIDTH, 32, word width in bits (must be 32; byte-lane logic assumes 4 lanes).
- MEMORY_DEPTH, 256, number of words (power of two).
- BASE_ADDRESS, 32'h1001_0000, byte address of word 0.
- CLEAR_ON_RESET, 1, if 1 run the zero-fill sweep after reset; if 0 go straight to IDLE.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Mem_Write_i  in  1  store request, sampled in IDLE.
- Mem_Read_i  in  1  load request, sampled in IDLE.
- Funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Address_i  in  32  byte address.
- Write_Data_i  in  DATA_WIDTH  store data, right-justified.
- Read_Data_o  out  DATA_WIDTH  extended load result, registered.
- Read_Valid_o  out  1  one-cycle strobe, Read_Data_o valid.
- Busy_o  out  1  high during clear sweep; requests ignored.
- Misaligned_o  out  1  one-cycle fault strobe.
- Access_Fault_o  out  1  one-cycle strobe: out of range or illegal funct3.

Behaviour:
- Reset (async, low): all outputs 0, state INIT if CLEAR_ON_RESET else IDLE, clear counter 0. Reset mid-access drops any pending read; no strobe follows.
- FSM: INIT -> IDLE after writing zero to words 0..MEMORY_DEPTH-1, one word per cycle (exactly MEMORY_DEPTH cycles, Busy_o=1 throughout, 0 the cycle IDLE is entered). IDLE <-> RESP: a load accepted in IDLE moves to RESP for one cycle, then returns to IDLE. Stores stay in IDLE.
- Address: offset = Address_i - BASE_ADDRESS (32-bit unsigned wrap); word index = offset[log2(MEMORY_DEPTH)+1:2]. Out of range when offset >= 4*MEMORY_DEPTH (addresses below base wrap high and fault).
- Alignment: H/HU need offset[0]=0; W needs offset[1:0]=0; B/BU never misaligned. Funct3 011, 110, 111 illegal (store: only 000/001/010 legal).
- Store (Mem_Write_i=1 in IDLE): on the same edge, write enabled lanes only. SB lane = offset[1:0], data byte replicated; SH lanes {offset[1],0} pair; SW all lanes. Untouched lanes keep their value.
- Load (Mem_Read_i=1, Mem_Write_i=0 in IDLE): RAM word read on accept edge; next cycle (RESP) Read_Valid_o=1, Read_Data_o = selected lane(s) sign-extended (B/H) or zero-extended (BU/HU); W unchanged. No new request accepted in RESP (1 request per 2 cycles).
- Both Mem_Write_i and Mem_Read_i high: store wins, no read strobe.
- Fault (misaligned, out of range, or illegal funct3): no RAM update; matching fault strobe high the cycle after the request. A faulted load still gives Read_Valid_o=1 with Read_Data_o=0, so the pipeline never hangs. Misaligned and out-of-range may assert together.
- Read_Data_o holds its last value when Read_Valid_o=0.
- Requests during INIT or RESP: ignored silently; no write, no strobe.

Decomposition:
- Shared package rv_mem_pkg: funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state enum (INIT, IDLE, RESP), byte-lane width constant 4.
- One natural sub-module, load_extend: combinational lane select plus sign/zero extension from funct3 and offset[1:0].
- Store lane-enable/replication stays inline.

Test Plan:
- Release reset, idle 300 cycles -> Busy_o high exactly 256 cycles; LW at 0x1001_03FC then returns 0.
- SW 0xDEADBEEF @0x1001_0010, then SB 0x55 @0x1001_0011 -> LW @0x1001_0010 gives 0xDEAD55EF with Read_Valid_o one cycle after accept.
- LB @0x1001_0013 -> 0xFFFFFFDE; LBU -> 0x000000DE; LH @0x1001_0012 -> 0xFFFFDEAD; LHU -> 0x0000DEAD.
- SW @0x1001_0002 -> Misaligned_o pulse, memory unchanged; LH @0x1001_0001 -> Misaligned_o plus Read_Valid_o with data 0.
- LW @0x1001_0400 and @0x1000_FFFC -> Access_Fault_o pulse, data 0; funct3=011 load -> Access_Fault_o.
- Assert reset during RESP -> no Read_Valid_o; Busy_o reasserts and memory rereads as zero after sweep.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32 data memory: funct3 access encodings,
// controller states and the byte-lane count of a data word.
package rv_mem_pkg;

    // Load/store size and sign encodings carried in funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte lanes per 32-bit word
    localparam int LANES = 4;

    // Controller states: zero-fill sweep, ready, load response
    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/data_memory_rv32_load_extend.sv
// Load formatter: picks the addressed byte or halfword out of a RAM word and
// sign- or zero-extends it according to funct3. Unknown encodings give 0.
module load_extend
    import rv_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  byte_off_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension
    always_comb begin
        byte_sel = word_i[{byte_off_i, 3'b000} +: 8];
        half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = 32'd0;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'd0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'd0, half_sel};
            F3_W:    data_o = word_i;
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_memory_rv32.sv
// RV32 data memory: word-organised RAM with byte-lane stores, registered
// loads with a valid strobe, base-address translation, alignment/range
// fault strobes and a zero-fill sweep after reset (Busy_o during the sweep).
module data_memory_rv32
    import rv_mem_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          MEMORY_DEPTH   = 256,
    parameter logic [31:0] BASE_ADDRESS   = 32'h1001_0000,
    parameter int          CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Mem_Write_i,
    input  logic                  Mem_Read_i,
    input  logic [2:0]            Funct3_i,
    input  logic [31:0]           Address_i,
    input  logic [DATA_WIDTH-1:0] Write_Data_i,
    output logic [DATA_WIDTH-1:0] Read_Data_o,
    output logic                  Read_Valid_o,
    output logic                  Busy_o,
    output logic                  Misaligned_o,
    output logic                  Access_Fault_o
);

    localparam int AW = $clog2(MEMORY_DEPTH);

    // Controller state
    mem_state_e     state_q;
    logic [AW-1:0]  clear_cnt_q;
    logic [2:0]     f3_q;
    logic [1:0]     off_q;
    logic           ld_fault_q;
    logic           valid_q;
    logic           mis_q;
    logic           af_q;
    logic [31:0]    data_hold_q;

    // RAM and its registered read port
    logic [31:0]    mem_q [MEMORY_DEPTH];
    logic [31:0]    rd_word_q;

    // Request decode
    logic [31:0]    offset;
    logic [AW-1:0]  word_idx;
    logic           out_of_range;
    logic           misaligned;
    logic           illegal_ld;
    logic           illegal_st;
    logic           st_acc;
    logic           ld_acc;
    logic           st_fault;
    logic           ld_fault;

    // RAM write port
    logic [LANES-1:0] ram_we;
    logic [31:0]      ram_wdata;
    logic [AW-1:0]    ram_widx;

    logic [31:0]      ext_raw;
    logic [31:0]      ext_data;

    // Address translation, alignment and legality checks
    always_comb begin
        offset       = Address_i - BASE_ADDRESS;
        word_idx     = offset[AW+1:2];
        out_of_range = |offset[31:AW+2];
        misaligned   = 1'b0;
        case (Funct3_i)
            F3_H, F3_HU: misaligned = offset[0];
            F3_W:        misaligned = |offset[1:0];
            default:     misaligned = 1'b0;
        endcase
        illegal_ld = (Funct3_i == 3'b011) || (Funct3_i == 3'b110) || (Funct3_i == 3'b111);
        illegal_st = (Funct3_i != F3_B) && (Funct3_i != F3_H) && (Funct3_i != F3_W);
        st_acc     = (state_q == IDLE) && Mem_Write_i;
        ld_acc     = (state_q == IDLE) && Mem_Read_i && !Mem_Write_i;
        st_fault   = misaligned || out_of_range || illegal_st;
        ld_fault   = misaligned || out_of_range || illegal_ld;
    end

    // Write-port steering: clear sweep, or lane enables and data replication for a store
    always_comb begin
        ram_we    = '0;
        ram_wdata = 32'd0;
        ram_widx  = word_idx;
        if (state_q == INIT) begin
            ram_we   = '1;
            ram_widx = clear_cnt_q;
        end else if (st_acc && !st_fault) begin
            case (Funct3_i)
                F3_B: begin
                    ram_wdata = {4{Write_Data_i[7:0]}};
                    ram_we    = 4'b0001 << offset[1:0];
                end
                F3_H: begin
                    ram_wdata = {2{Write_Data_i[15:0]}};
                    ram_we    = offset[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    ram_wdata = Write_Data_i[31:0];
                    ram_we    = 4'b1111;
                end
            endcase
        end
    end

    // Byte-lane RAM writes and the registered word read on load accept
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (ram_we[i]) begin
                mem_q[ram_widx][i*8 +: 8] <= ram_wdata[i*8 +: 8];
            end
        end
        if (ld_acc) begin
            rd_word_q <= mem_q[word_idx];
        end
    end

    load_extend u_load_extend (
        .word_i     (rd_word_q),
        .funct3_i   (f3_q),
        .byte_off_i (off_q),
        .data_o     (ext_raw)
    );

    // A faulted load still answers, but with zero data
    assign ext_data = ld_fault_q ? 32'd0 : ext_raw;

    // Controller FSM, fault strobes and load-response bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? INIT : IDLE;
            clear_cnt_q <= '0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            ld_fault_q  <= 1'b0;
            valid_q     <= 1'b0;
            mis_q       <= 1'b0;
            af_q        <= 1'b0;
            data_hold_q <= 32'd0;
        end else begin
            valid_q <= 1'b0;
            mis_q   <= (st_acc || ld_acc) && misaligned;
            af_q    <= (st_acc && (out_of_range || illegal_st)) ||
                       (ld_acc && (out_of_range || illegal_ld));
            if (valid_q) begin
                data_hold_q <= ext_data;
            end
            case (state_q)
                INIT: begin
                    clear_cnt_q <= clear_cnt_q + 1'b1;
                    if (clear_cnt_q == AW'(MEMORY_DEPTH - 1)) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (ld_acc) begin
                        state_q    <= RESP;
                        valid_q    <= 1'b1;
                        f3_q       <= Funct3_i;
                        off_q      <= offset[1:0];
                        ld_fault_q <= ld_fault;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data is live during the response cycle and held from then on
    assign Read_Data_o    = DATA_WIDTH'(valid_q ? ext_data : data_hold_q);
    assign Read_Valid_o   = valid_q;
    assign Misaligned_o   = mis_q;
    assign Access_Fault_o = af_q;
    // Forced low while reset is held so every output reads 0 in reset
    assign Busy_o         = reset && (state_q == INIT);

endmodule

// File: tb/tb_data_memory_rv32.sv
// Self-checking bench for data_memory_rv32: a vector table of loads/stores
// with expected strobes/data fed through a scoreboard queue, plus hand
// sequences for the clear sweep, requests in RESP and reset during RESP.
module tb_data_memory_rv32;

    logic        clk = 1'b0;
    logic        reset;
    logic        Mem_Write_i;
    logic        Mem_Read_i;
    logic [2:0]  Funct3_i;
    logic [31:0] Address_i;
    logic [31:0] Write_Data_i;
    logic [31:0] Read_Data_o;
    logic        Read_Valid_o;
    logic        Busy_o;
    logic        Misaligned_o;
    logic        Access_Fault_o;

    int errors = 0;
    int checks = 0;

    data_memory_rv32 dut (
        .clk            (clk),
        .reset          (reset),
        .Mem_Write_i    (Mem_Write_i),
        .Mem_Read_i     (Mem_Read_i),
        .Funct3_i       (Funct3_i),
        .Address_i      (Address_i),
        .Write_Data_i   (Write_Data_i),
        .Read_Data_o    (Read_Data_o),
        .Read_Valid_o   (Read_Valid_o),
        .Busy_o         (Busy_o),
        .Misaligned_o   (Misaligned_o),
        .Access_Fault_o (Access_Fault_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ev;
        logic [31:0] ed;
        logic        em;
        logic        ea;
    } vec_t;

    typedef struct {
        int          id;
        logic        ev;
        logic [31:0] ed;
        logic        em;
        logic        ea;
    } exp_t;

    vec_t vecs[24];
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Mem_Write_i  = 1'b0;
        Mem_Read_i   = 1'b0;
        Funct3_i     = 3'b000;
        Address_i    = 32'd0;
        Write_Data_i = 32'd0;
    endtask

    // Drive one request, push its expectation, compare in the following cycle
    task automatic issue(input int id, input vec_t v);
        exp_t e;
        @(negedge clk);
        Mem_Write_i  = v.wr;
        Mem_Read_i   = v.rd;
        Funct3_i     = v.f3;
        Address_i    = v.addr;
        Write_Data_i = v.wdata;
        sb_q.push_back('{id, v.ev, v.ed, v.em, v.ea});
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        e = sb_q.pop_front();
        $display("txn %0d wr=%b rd=%b f3=%b addr=%h -> valid=%b data=%h mis=%b af=%b",
                 e.id, v.wr, v.rd, v.f3, v.addr, Read_Valid_o, Read_Data_o,
                 Misaligned_o, Access_Fault_o);
        chk($sformatf("txn%0d valid", e.id), {31'd0, Read_Valid_o}, {31'd0, e.ev});
        chk($sformatf("txn%0d misaligned", e.id), {31'd0, Misaligned_o}, {31'd0, e.em});
        chk($sformatf("txn%0d access_fault", e.id), {31'd0, Access_Fault_o}, {31'd0, e.ea});
        if (e.ev) chk($sformatf("txn%0d data", e.id), Read_Data_o, e.ed);
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (Busy_o) n++;
        end
        $display("sweep %s: busy cycles=%0d", nm, n);
        chk(nm, n, 256);
    endtask

    initial begin
        //          wr    rd    f3      addr           wdata          ev    ed             em    ea
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h1001_03FC, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h1001_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h1001_0011, 32'h0000_0055, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h1001_0010, 32'h0,         1'b1, 32'hDEAD_55EF, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'b000, 32'h1001_0013, 32'h0,         1'b1, 32'hFFFF_FFDE, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'b100, 32'h1001_0013, 32'h0,         1'b1, 32'h0000_00DE, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h1001_0012, 32'h0,         1'b1, 32'hFFFF_DEAD, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b101, 32'h1001_0012, 32'h0,         1'b1, 32'h0000_DEAD, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h1001_0002, 32'h1234_5678, 1'b0, 32'h0,         1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h1001_0010, 32'h0,         1'b1, 32'hDEAD_55EF, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h1001_0001, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'b010, 32'h1001_0400, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 3'b010, 32'h1000_FFFC, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 3'b011, 32'h1001_0010, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 3'b001, 32'h1001_0012, 32'h1234_ABCD, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 3'b010, 32'h1001_0010, 32'h0,         1'b1, 32'hABCD_55EF, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 3'b000, 32'h1001_0011, 32'h0,         1'b1, 32'h0000_0055, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 3'b001, 32'h1001_0010, 32'h0,         1'b1, 32'h0000_55EF, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 3'b010, 32'h1001_0020, 32'h1122_3344, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 3'b010, 32'h1001_0020, 32'h0,         1'b1, 32'h1122_3344, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 3'b100, 32'h1001_0020, 32'h0000_00FF, 1'b0, 32'h0,         1'b0, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 3'b010, 32'h1001_0020, 32'h0,         1'b1, 32'h1122_3344, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 3'b010, 32'h1001_0402, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 1'b1};
        vecs[23] = '{1'b0, 1'b1, 3'b100, 32'h1001_0023, 32'h0,         1'b1, 32'h0000_0011, 1'b0, 1'b0};

        reset = 1'b0;
        idle_inputs();

        // Outputs in reset
        repeat (3) @(negedge clk);
        chk("reset valid", {31'd0, Read_Valid_o}, 32'd0);
        chk("reset busy", {31'd0, Busy_o}, 32'd0);
        chk("reset mis", {31'd0, Misaligned_o}, 32'd0);
        chk("reset af", {31'd0, Access_Fault_o}, 32'd0);
        chk("reset data", Read_Data_o, 32'd0);

        // Release just after an edge, then watch the clear sweep
        @(posedge clk);
        #1 reset = 1'b1;
        count_busy("busy after reset");

        for (int i = 0; i < 24; i++) begin
            issue(i, vecs[i]);
        end

        // Read_Data_o holds the last load result while no strobe
        @(negedge clk);
        chk("hold valid", {31'd0, Read_Valid_o}, 32'd0);
        chk("hold data", Read_Data_o, 32'h0000_0011);

        // A store presented during RESP is ignored
        @(negedge clk);
        Mem_Read_i = 1'b1;
        Funct3_i   = 3'b010;
        Address_i  = 32'h1001_0020;
        @(posedge clk);
        #1;
        Mem_Read_i   = 1'b0;
        Mem_Write_i  = 1'b1;
        Write_Data_i = 32'h0;
        @(negedge clk);
        chk("resp valid", {31'd0, Read_Valid_o}, 32'd1);
        chk("resp data", Read_Data_o, 32'h1122_3344);
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        $display("txn resp-store: valid=%b mis=%b af=%b", Read_Valid_o, Misaligned_o, Access_Fault_o);
        chk("ignored valid", {31'd0, Read_Valid_o}, 32'd0);
        chk("ignored af", {31'd0, Access_Fault_o}, 32'd0);
        issue(100, vecs[21]);

        // Reset while a load is in RESP: no strobe, sweep reruns
        @(negedge clk);
        Mem_Read_i = 1'b1;
        Funct3_i   = 3'b010;
        Address_i  = 32'h1001_0020;
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        $display("txn reset-in-resp: valid=%b busy=%b data=%h", Read_Valid_o, Busy_o, Read_Data_o);
        chk("rst resp valid", {31'd0, Read_Valid_o}, 32'd0);
        chk("rst resp busy", {31'd0, Busy_o}, 32'd0);
        chk("rst resp data", Read_Data_o, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        count_busy("busy after second reset");
        issue(101, '{1'b0, 1'b1, 3'b010, 32'h1001_0020, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0});
        issue(102, '{1'b0, 1'b1, 3'b010, 32'h1001_0010, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
